// File: rtl/core_myoutput.sv
// rtl/core_myoutput.sv - Avalon-MM output port with set/clear and timed pulse generator
module core_myoutput #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PLEN   = 3'd1;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] active_mask;
    logic [15:0]      plen_reg;
    logic [15:0]      count;
    logic [31:0]      rd_next;

    logic             wr_en;
    logic [WIDTH-1:0] wr_mask;
    logic             busy;
    logic             pulse_wr;
    logic             pulse_start;
    logic             pulse_cancel;

    assign wr_en   = chipselect && !write_n;
    assign wr_mask = writedata[WIDTH-1:0];
    assign busy    = (count != 16'd0);

    // A PULSE write with an empty mask cancels; a non-empty mask only starts
    // when a length is programmed, otherwise it is treated as if absent.
    assign pulse_wr     = wr_en && (address == ADDR_PULSE);
    assign pulse_cancel = pulse_wr && (wr_mask == '0);
    assign pulse_start  = pulse_wr && (wr_mask != '0) && (plen_reg != 16'd0);

    // Both terms are registers, so the pins reset combinationally with them.
    assign out_port = data_reg | active_mask;

    // Static output level: direct write, bitwise set and bitwise clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:   data_reg <= wr_mask;
                ADDR_OUTSET: data_reg <= data_reg | wr_mask;
                ADDR_OUTCLR: data_reg <= data_reg & ~wr_mask;
                default:     data_reg <= data_reg;
            endcase
        end
    end

    // Pulse length; only sampled when a pulse starts, never alters a running one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plen_reg <= 16'd0;
        end else if (wr_en && (address == ADDR_PLEN)) begin
            plen_reg <= writedata[15:0];
        end
    end

    // Pulse counter and mask: start/retrigger replaces, cancel clears, mask drops with the last count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count       <= 16'd0;
            active_mask <= '0;
        end else if (pulse_cancel) begin
            count       <= 16'd0;
            active_mask <= '0;
        end else if (pulse_start) begin
            count       <= plen_reg;
            active_mask <= wr_mask;
        end else if (busy) begin
            count <= count - 16'd1;
            if (count == 16'd1) begin
                active_mask <= '0;
            end
        end
    end

    // Read mux from pre-edge state so a same-cycle write is not visible yet.
    always_comb begin
        rd_next = 32'd0;
        case (address)
            ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR: rd_next[WIDTH-1:0] = data_reg;
            ADDR_PLEN:   rd_next[15:0] = plen_reg;
            ADDR_PULSE: begin
                rd_next[15:0]      = count;
                rd_next[16 +: WIDTH] = active_mask;
            end
            ADDR_STATUS: rd_next[0] = busy;
            default:     rd_next = 32'd0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_core_myoutput.sv
// tb/tb_core_myoutput.sv - randomized model-based bench for core_myoutput
module tb_core_myoutput;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic [2:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] out_port;

    int n_checks;
    int n_fail;

    // Reference model: a pulse is a time window [start edge, m_end) in edge counts.
    int           cyc;
    logic [W-1:0] m_data;
    logic [15:0]  m_plen;
    logic [W-1:0] m_mask;
    int           m_end;

    core_myoutput #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_active();
        return cyc < m_end;
    endfunction

    function automatic logic [W-1:0] m_out();
        return m_data | (m_active() ? m_mask : '0);
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            3'd0, 3'd4, 3'd5: r[W-1:0] = m_data;
            3'd1: r[15:0] = m_plen;
            3'd2: if (m_active()) begin
                r[15:0]     = 16'(m_end - cyc);
                r[16 +: W]  = m_mask;
            end
            3'd3: r[0] = m_active();
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic m_reset();
        m_data = '0;
        m_plen = 16'd0;
        m_mask = '0;
        m_end  = 0;
    endtask

    task automatic m_write(input logic [2:0] a, input logic [31:0] wd);
        logic [W-1:0] mk;
        mk = wd[W-1:0];
        case (a)
            3'd0: m_data = mk;
            3'd1: m_plen = wd[15:0];
            3'd2: begin
                if (mk == '0) begin
                    m_end  = 0;
                    m_mask = '0;
                end else if (m_plen != 16'd0) begin
                    m_end  = cyc + int'(m_plen);
                    m_mask = mk;
                end
            end
            3'd4: m_data = m_data | mk;
            3'd5: m_data = m_data & ~mk;
            default: ;
        endcase
    endtask

    // One bus cycle: drive, predict, clock, then check pins and read data.
    task automatic do_cycle(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        logic [31:0]  exp_rd;
        logic [W-1:0] exp_out;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        exp_rd = m_read(a);
        @(posedge clk);
        cyc = cyc + 1;
        if (cs && !wn) m_write(a, wd);
        #1;
        exp_out = m_out();
        n_checks++;
        if (out_port !== exp_out) begin
            n_fail++;
            $display("FAIL out_port cyc=%0d actual=%h expected=%h", cyc, out_port, exp_out);
        end
        n_checks++;
        if (readdata !== exp_rd) begin
            n_fail++;
            $display("FAIL readdata cyc=%0d addr=%0d actual=%h expected=%h", cyc, a, readdata, exp_rd);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        do_cycle(a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd(input logic [2:0] a);
        do_cycle(a, 1'b0, 1'b1, 32'd0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_port !== '0) begin n_fail++; $display("FAIL reset_out actual=%h expected=0", out_port); end
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_rd actual=%h expected=0", readdata); end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) rd(3'(i));
    endtask

    task automatic test_data_rw();
        wr(3'd0, 32'h0000_000A);
        n_checks++;
        if (out_port !== 4'hA) begin n_fail++; $display("FAIL data_out actual=%h expected=a", out_port); end
        rd(3'd0);
        rd(3'd0);
        n_checks++;
        if (readdata !== 32'h0000_000A) begin n_fail++; $display("FAIL data_rd actual=%h expected=0000000a", readdata); end
    endtask

    task automatic test_set_clr();
        wr(3'd0, 32'h1);
        wr(3'd4, 32'h6);
        n_checks++;
        if (out_port !== 4'h7) begin n_fail++; $display("FAIL outset actual=%h expected=7", out_port); end
        wr(3'd5, 32'h3);
        n_checks++;
        if (out_port !== 4'h4) begin n_fail++; $display("FAIL outclr actual=%h expected=4", out_port); end
        rd(3'd4);
        rd(3'd5);
    endtask

    task automatic test_pulse();
        int high_cycles;
        wr(3'd1, 32'd5);
        wr(3'd0, 32'd0);
        wr(3'd2, 32'h8);
        high_cycles = (out_port == 4'h8) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            rd(3'd2);
            if (out_port == 4'h8) high_cycles++;
        end
        n_checks++;
        if (high_cycles !== 5) begin n_fail++; $display("FAIL pulse_len actual=%0d expected=5", high_cycles); end
        rd(3'd3);
        rd(3'd3);
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL pulse_busy_after actual=%h expected=0", readdata); end
    endtask

    task automatic test_retrigger_cancel();
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h1);
        repeat (4) rd(3'd2);
        wr(3'd2, 32'h2);
        n_checks++;
        if (out_port !== 4'h2) begin n_fail++; $display("FAIL retrigger actual=%h expected=2", out_port); end
        repeat (5) rd(3'd3);
        wr(3'd1, 32'd3);
        rd(3'd2);
        wr(3'd2, 32'h0);
        n_checks++;
        if (out_port !== 4'h0) begin n_fail++; $display("FAIL cancel actual=%h expected=0", out_port); end
        rd(3'd3);
        rd(3'd3);
    endtask

    task automatic test_ignored_writes();
        wr(3'd1, 32'd0);
        wr(3'd2, 32'hF);
        rd(3'd3);
        rd(3'd2);
        do_cycle(3'd6, 1'b0, 1'b0, 32'hFFFF_FFFF);
        do_cycle(3'd6, 1'b1, 1'b1, 32'hFFFF_FFFF);
        wr(3'd6, 32'hFFFF_FFFF);
        do_cycle(3'd0, 1'b0, 1'b0, 32'h5);
        do_cycle(3'd1, 1'b1, 1'b1, 32'h7);
        rd(3'd6);
        rd(3'd7);
        rd(3'd0);
        rd(3'd1);
    endtask

    task automatic test_reset_mid_pulse();
        wr(3'd1, 32'd100);
        wr(3'd2, 32'hF);
        repeat (19) rd(3'd2);
        reset_n = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if (out_port !== '0) begin n_fail++; $display("FAIL async_reset_out actual=%h expected=0", out_port); end
        n_checks++;
        if (readdata !== 32'd0) begin n_fail++; $display("FAIL async_reset_rd actual=%h expected=0", readdata); end
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        reset_n = 1'b1;
        rd(3'd3);
        rd(3'd3);
        n_checks++;
        if (readdata[0] !== 1'b0) begin n_fail++; $display("FAIL busy_after_reset actual=%b expected=0", readdata[0]); end
        rd(3'd2);
        rd(3'd1);
    endtask

    task automatic test_random();
        logic [2:0]  a;
        logic [31:0] wd;
        for (int i = 0; i < 400; i++) begin
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd1) wd = 32'($urandom_range(0, 12));
            if (a == 3'd2 && $urandom_range(0, 5) == 0) wd = 32'd0;
            do_cycle(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0 ? 1 : 0) ^ 1'b0 ? 1'b1 : 1'b0, wd);
        end
    endtask

    task automatic test_back_to_back();
        wr(3'd1, 32'd4);
        wr(3'd2, 32'h3);
        wr(3'd2, 32'h5);
        wr(3'd1, 32'd2);
        wr(3'd4, 32'h8);
        wr(3'd2, 32'h0);
        wr(3'd2, 32'h6);
        wr(3'd5, 32'hF);
        repeat (4) rd(3'd2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        test_reset();
        test_data_rw();
        test_set_clr();
        test_pulse();
        test_retrigger_cancel();
        test_ignored_writes();
        test_reset_mid_pulse();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
